// File: rtl/sync_edge_event_latch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge_event_latch_pkg
//  Brief    : Shared constants for the edge-event latch and its synchronizer.
//  Revision : 1.0  initial release
// ============================================================================
package sync_edge_event_latch_pkg;

    // The metastability filter never uses fewer stages than this.
    localparam int unsigned MIN_SYNC_STAGES = 2;

    function automatic int unsigned calc_sync_depth(input int unsigned extra);
        return MIN_SYNC_STAGES + extra;
    endfunction

endpackage : sync_edge_event_latch_pkg
`default_nettype wire

// File: rtl/sync_edge_event_latch_bit_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module   : bit_sync_chain
//  Brief    : Plain flop chain that brings a foreign-domain level into clock.
//  Revision : 1.0  initial release
// ============================================================================
module bit_sync_chain #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clock,
    input  logic bit_in,
    output logic bit_out
);

    // Power-up value of zero keeps the downstream edge detector quiet at start.
    (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] r_sync = '0;

    always_ff @(posedge clock) begin
        r_sync <= {r_sync[DEPTH-2:0], bit_in};
    end

    assign bit_out = r_sync[DEPTH-1];

endmodule : bit_sync_chain
`default_nettype wire

// File: rtl/sync_edge_event_latch.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge_event_latch
//  Brief    : Synchronizes an async level, flags its edges, latches an event.
//  Revision : 1.0  initial release
// ============================================================================
module sync_edge_event_latch
    import sync_edge_event_latch_pkg::*;
#(
    parameter int unsigned EXTRA_DEPTH = 0
) (
    input  logic clock,
    input  logic clear,
    input  logic bit_in,
    input  logic latch_clear,
    output logic bit_out,
    output logic pulse_posedge_out,
    output logic pulse_negedge_out,
    output logic pulse_anyedge_out,
    output logic level_out
);

    localparam int unsigned SYNC_DEPTH = calc_sync_depth(EXTRA_DEPTH);

    logic w_bit_sync;
    // Not touched by clear, so a reset can never fabricate an edge.
    logic r_level_delayed = 1'b0;
    logic r_level         = 1'b0;

    bit_sync_chain #(
        .DEPTH   (SYNC_DEPTH)
    ) u_bit_sync_chain (
        .clock   (clock),
        .bit_in  (bit_in),
        .bit_out (w_bit_sync)
    );

    always_ff @(posedge clock) begin
        r_level_delayed <= w_bit_sync;
    end

    assign bit_out           = w_bit_sync;
    assign pulse_posedge_out = w_bit_sync & ~r_level_delayed;
    assign pulse_negedge_out = ~w_bit_sync & r_level_delayed;
    assign pulse_anyedge_out = w_bit_sync ^ r_level_delayed;

    // Consumer acknowledge outranks a coincident new event.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_level <= 1'b0;
        end else if (latch_clear) begin
            r_level <= 1'b0;
        end else if (pulse_anyedge_out) begin
            r_level <= 1'b1;
        end
    end

    assign level_out = r_level;

endmodule : sync_edge_event_latch
`default_nettype wire

// File: tb/tb_sync_edge_event_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_edge_event_latch
//  Brief    : Self-checking bench, two instances (2 and 4 sync stages).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_edge_event_latch;

    logic clk = 1'b0;
    logic clear = 1'b0;
    logic bit_in = 1'b0;
    logic latch_clear = 1'b0;
    logic bo [2];
    logic pp [2];
    logic pn [2];
    logic pa [2];
    logic lv [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_edge_event_latch #(.EXTRA_DEPTH(0)) dut0 (
        .clock(clk), .clear(clear), .bit_in(bit_in), .latch_clear(latch_clear),
        .bit_out(bo[0]), .pulse_posedge_out(pp[0]), .pulse_negedge_out(pn[0]),
        .pulse_anyedge_out(pa[0]), .level_out(lv[0])
    );

    sync_edge_event_latch #(.EXTRA_DEPTH(2)) dut2 (
        .clock(clk), .clear(clear), .bit_in(bit_in), .latch_clear(latch_clear),
        .bit_out(bo[1]), .pulse_posedge_out(pp[1]), .pulse_negedge_out(pn[1]),
        .pulse_anyedge_out(pa[1]), .level_out(lv[1])
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bit_out is simply the bit_in sampled DEPTH edges ago.
    int unsigned m_depth [2] = '{2, 4};
    bit          m_hist [$];
    bit          m_out  [2] = '{1'b0, 1'b0};
    bit          m_prev [2] = '{1'b0, 1'b0};
    bit          m_lvl  [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        m_hist.push_front(bit_in);
        if (m_hist.size() > 8) void'(m_hist.pop_back());
        for (int k = 0; k < 2; k++) begin
            if (clear || latch_clear) m_lvl[k] = 1'b0;
            else if (m_out[k] != m_prev[k]) m_lvl[k] = 1'b1;
            m_prev[k] = m_out[k];
            m_out[k]  = (m_hist.size() >= m_depth[k]) ? m_hist[m_depth[k]-1] : 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_bit_out[%0d]", k), bo[k], m_out[k]);
            chk($sformatf("model_pos[%0d]", k), pp[k], m_out[k] & ~m_prev[k]);
            chk($sformatf("model_neg[%0d]", k), pn[k], ~m_out[k] & m_prev[k]);
            chk($sformatf("model_any[%0d]", k), pa[k], m_out[k] ^ m_prev[k]);
            chk($sformatf("model_level[%0d]", k), lv[k], m_lvl[k]);
        end
    end

    bit count_en = 1'b0;
    int any_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        if (count_en) begin
            for (int k = 0; k < 2; k++) if (pa[k]) any_cnt[k]++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int toggles = 0;

    initial begin
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("powerup_bit_out", bo[k], 1'b0);
            chk("powerup_any", pa[k], 1'b0);
            chk("powerup_level", lv[k], 1'b0);
        end

        // Rising transition seen through the 2-stage instance.
        bit_in = 1'b1;
        step();
        chk("rise_c1_bit_out", bo[0], 1'b0);
        step();
        chk("rise_c2_bit_out", bo[0], 1'b1);
        chk("rise_c2_pos", pp[0], 1'b1);
        chk("rise_c2_any", pa[0], 1'b1);
        chk("rise_c2_level", lv[0], 1'b0);
        step();
        chk("rise_c3_pos", pp[0], 1'b0);
        chk("rise_c3_any", pa[0], 1'b0);
        chk("rise_c3_level", lv[0], 1'b1);
        repeat (6) step();
        chk("rise_level_d2", lv[1], 1'b1);

        // Acknowledge drops the latch and it stays down.
        latch_clear = 1'b1;
        step();
        latch_clear = 1'b0;
        chk("ack_level", lv[0], 1'b0);
        repeat (5) step();
        chk("ack_level_held", lv[0], 1'b0);

        // Falling transition through the 4-stage instance.
        bit_in = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk($sformatf("fall_d4_neg_c%0d", c), pn[1], (c == 4));
            chk($sformatf("fall_d4_pos_c%0d", c), pp[1], 1'b0);
            if (c == 2) chk("fall_d2_neg_c2", pn[0], 1'b1);
        end
        repeat (4) step();
        latch_clear = 1'b1;
        step();
        latch_clear = 1'b0;

        // Acknowledge coinciding with the event pulse wins.
        bit_in = 1'b1;
        step();
        step();
        chk("coincide_any", pa[0], 1'b1);
        latch_clear = 1'b1;
        step();
        latch_clear = 1'b0;
        chk("coincide_level", lv[0], 1'b0);
        repeat (6) step();
        chk("coincide_level_held", lv[0], 1'b0);
        chk("coincide_level_d4", lv[1], 1'b1);

        // Mid-run clear with bit_in held high.
        clear = 1'b1;
        repeat (4) step();
        chk("clear_level0", lv[0], 1'b0);
        chk("clear_level1", lv[1], 1'b0);
        clear = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                chk("post_clear_any", pa[k], 1'b0);
                chk("post_clear_bit_out", bo[k], 1'b1);
                chk("post_clear_level", lv[k], 1'b0);
            end
        end

        // Random legal toggles: one pulse per toggle.
        count_en = 1'b1;
        for (int t = 0; t < 20; t++) begin
            bit_in = ~bit_in;
            toggles++;
            repeat ($urandom_range(8, 5)) step();
        end
        repeat (8) step();
        count_en = 1'b0;
        chk_int("pulse_count_d2", any_cnt[0], toggles);
        chk_int("pulse_count_d4", any_cnt[1], toggles);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sync_edge_event_latch
`default_nettype wire
